tytra_map_mul_pipe: RTL and testbench
=====================================

Name: tytra_map_mul_pipe

Overview:
- Parametrised leaf map node for TyBEC-generated kernels: a pipelined integer multiplier with stream valid/ready handshake.
- Supersedes the single-register constant multiplier node with four additions:
  - configurable latency
  - constant-operand or two-stream mode
  - signed/unsigned arithmetic
  - bubble-collapsing per-stage stall, so that backpressure does not drop or duplicate items
- Sits between upstream and downstream map/fold nodes inside a generated kernel.

Parameters:
- DATAW, 32, operand width in bits.
- OUTW, 32, output width; the low OUTW bits of the 2*DATAW product are kept. Legal range 1..2*DATAW.
- LAT, 2, pipeline depth in register stages; LAT >= 1.
- USE_CONST, 1, 1 = in2 is the constant CONST_VAL (in2 and ivalid_in2 are ignored); 0 = in2 is a stream.
- CONST_VAL, 432, constant operand, DATAW bits.
- SIGNED, 0, 1 = two's-complement multiply; 0 = unsigned.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- ivalid_in1  input  1  in1 valid
- in1  input  DATAW  operand A
- ivalid_in2  input  1  in2 valid (unused when USE_CONST=1)
- in2  input  DATAW  operand B (unused when USE_CONST=1)
- iready  output  1  node accepts an input item this cycle
- ovalid  output  1  out1 holds a valid result
- out1  output  OUTW  product
- oready  input  1  downstream accepts
- busy  output  1  at least one stage holds a valid item

Behaviour:
- Stages s = 0..LAT-1, each with a data register d[s] and a valid bit v[s]. Stage LAT-1 drives out1 and ovalid.
- Join:
  - ivalid = ivalid_in1 & (USE_CONST ? 1 : ivalid_in2).
  - iready is shared by both input streams.
  - A transfer occurs when ivalid & iready.
- Advance rule (bubble collapse):
  - adv[LAT-1] = ~v[LAT-1] | oready.
  - adv[s] = ~v[s] | adv[s+1] for s < LAT-1.
  - iready = adv[0]. This is combinational from oready; no register on the ready path.
- When adv[s] is high:
  - Stage s loads from stage s-1, or from the input for s = 0.
  - v[s] takes v[s-1], or the input transfer bit for s = 0.
- When adv[s] is low, d[s] and v[s] hold.
- An empty stage always accepts, so a bubble ahead of a stalled stage is filled even while oready = 0.
- Datapath:
  - LAT = 1: the product is formed combinationally from the inputs and registered in stage 0.
  - LAT >= 2: stage 0 registers the operands; the product is formed between stage 0 and stage 1; stages 2..LAT-1 are pure delay.
  - Product width is 2*DATAW, with $signed operands when SIGNED = 1. out1 = product[OUTW-1:0]. Overflow wraps silently.
- Latency:
  - An item accepted at edge k appears on out1 with ovalid = 1 after edge k+LAT-1, i.e. LAT cycles after presentation, when oready stayed high.
  - Throughput is 1 item/cycle while oready = 1.
- Output stability: while ovalid = 1 and oready = 0, out1 and ovalid hold stable.
- ovalid = v[LAT-1] and is not gated by oready (item-dropping is prohibited).
- busy = OR of all v[s].
- Reset:
  - All v[s] cleared and all d[s] cleared to 0, so ovalid = 0, out1 = 0, busy = 0.
  - After reset iready = 1, because the pipe is empty.
  - Reset mid-operation discards all in-flight items; there is no partial output after reset.
- Simultaneous events:
  - Full pipe with oready = 1 and ivalid = 1: the output drains and the input is accepted in the same cycle, so occupancy is unchanged.
  - Full pipe with oready = 0: iready = 0; the input is not consumed and upstream must hold it.
- Ordering: items exit in acceptance order; the node never reorders or duplicates.

Decomposition:
- Shared package tytra_map_pkg holds:
  - a stream handshake constant/typedef set (valid/ready bit type)
  - the default DATAW
  - a function for product truncation/sign handling, reused by the add/sub/div map nodes
- Natural sub-module: tytra_pipe_stage, one register slice with v/d/adv. It is instantiated LAT times via generate; stage 0 has a mux-free operand payload variant.

Test Plan:
- Constant mode, default params, in1 = 5 held valid one cycle, oready = 1 → out1 = 2160 with ovalid = 1 exactly 2 cycles after presentation; busy high for 2 cycles.
- Backpressure: stream in1 = 1,2,3,4,5 with oready = 0 from cycle 3 for 4 cycles → iready drops once both stages are full; output sequence 432, 864, 1296, 1728, 2160 with no loss or duplication; out1 stable during the stall.
- Bubble collapse, LAT = 4: inject one item, idle 2 cycles, inject a second, hold oready = 0 → the second item advances until stage 2 fills behind stage 3; iready = 1 while stage 0 is empty.
- Two-stream join, USE_CONST = 0: ivalid_in1 = 1, ivalid_in2 = 0 → no transfer, busy stays 0; then both valid with 7 and 9 → out1 = 63.
- SIGNED = 1, USE_CONST = 0: in1 = 0xFFFFFFFD (-3), in2 = 7 → out1 = 0xFFFFFFEB. OUTW = 32 unsigned: 0x10000 × 0x10000 → out1 = 0.
- Reset with 2 items in flight → next cycle ovalid = 0, out1 = 0, busy = 0, iready = 1; a post-reset item in1 = 1 yields out1 = 432 after LAT cycles.

Source files
------------

// File: rtl/tytra_map_pkg.sv
// Shared definitions for TyBEC map nodes: stream handshake bit type,
// default operand width and the sign/zero extension helper used by arithmetic nodes.
package tytra_map_pkg;

   typedef logic hs_bit_t;

   localparam hs_bit_t HS_ACTIVE     = 1'b1;
   localparam int      DEFAULT_DATAW = 32;

   // Fill bit used when widening an operand to the full product width.
   function automatic logic ext_fill(input logic msb, input bit is_signed);
      return is_signed & msb;
   endfunction

endpackage

// File: rtl/tytra_pipe_stage.sv
// One register slice of a bubble-collapsing valid/ready pipeline:
// holds payload d and valid bit v, and advances when empty or when the next stage advances.
module tytra_pipe_stage
   import tytra_map_pkg::*;
#(
   parameter int W = DEFAULT_DATAW
) (
   input  logic         clk,
   input  logic         rst,
   input  hs_bit_t      adv_next,
   input  hs_bit_t      v_in,
   input  logic [W-1:0] d_in,
   output hs_bit_t      adv,
   output hs_bit_t      v,
   output logic [W-1:0] d
);

   // An empty slice always accepts, which lets bubbles collapse under a stall.
   assign adv = ~v | adv_next;

   // NOTE: the payload is cleared on reset as well, so out1 reads 0 after reset, not stale data.
   always_ff @(posedge clk) begin
      if (rst) begin
         v <= 1'b0;
         d <= '0;
      end else if (adv) begin
         v <= v_in;
         d <= d_in;
      end
   end

endmodule

// File: rtl/tytra_map_mul_pipe.sv
// Pipelined integer multiplier map node with joined valid/ready inputs,
// optional constant operand, signed/unsigned mode and per-stage stall.
module tytra_map_mul_pipe
   import tytra_map_pkg::*;
#(
   parameter int               DATAW     = DEFAULT_DATAW,
   parameter int               OUTW      = 32,
   parameter int               LAT       = 2,
   parameter bit               USE_CONST = 1'b1,
   parameter logic [DATAW-1:0] CONST_VAL = DATAW'(432),
   parameter bit               SIGNED    = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ivalid_in1,
   input  logic [DATAW-1:0] in1,
   input  logic             ivalid_in2,
   input  logic [DATAW-1:0] in2,
   output logic             iready,
   output logic             ovalid,
   output logic [OUTW-1:0]  out1,
   input  logic             oready,
   output logic             busy
);

   hs_bit_t            ivalid;
   hs_bit_t            xfer;
   logic [DATAW-1:0]   op_b;
   logic [DATAW-1:0]   mul_a;
   logic [DATAW-1:0]   mul_b;
   logic [2*DATAW-1:0] ext_a;
   logic [2*DATAW-1:0] ext_b;
   logic [OUTW-1:0]    prod;
   logic [LAT:0]       adv;
   logic [LAT-1:0]     v_q;
   logic [OUTW-1:0]    d_q [LAT];
   logic               unused_in2;

   assign ivalid     = ivalid_in1 & (USE_CONST ? HS_ACTIVE : ivalid_in2);
   assign op_b       = USE_CONST ? CONST_VAL : in2;
   assign unused_in2 = ^{in2, ivalid_in2};

   // Ready ripples back combinationally from oready through the stall chain.
   assign adv[LAT] = oready;
   assign iready   = adv[0];
   assign xfer     = ivalid & iready;

   // Low bits of the widened product equal the 2*DATAW-bit signed/unsigned product.
   assign ext_a = {{DATAW{ext_fill(mul_a[DATAW-1], SIGNED)}}, mul_a};
   assign ext_b = {{DATAW{ext_fill(mul_b[DATAW-1], SIGNED)}}, mul_b};
   assign prod  = OUTW'(ext_a * ext_b);

   generate
      if (LAT == 1) begin : g_lat1
         assign mul_a = in1;
         assign mul_b = op_b;

         tytra_pipe_stage #(.W(OUTW)) u_stage0 (
            .clk      (clk),
            .rst      (rst),
            .adv_next (adv[1]),
            .v_in     (xfer),
            .d_in     (prod),
            .adv      (adv[0]),
            .v        (v_q[0]),
            .d        (d_q[0])
         );
      end else begin : g_latn
         logic [2*DATAW-1:0] op_q;

         tytra_pipe_stage #(.W(2*DATAW)) u_stage0 (
            .clk      (clk),
            .rst      (rst),
            .adv_next (adv[1]),
            .v_in     (xfer),
            .d_in     ({in1, op_b}),
            .adv      (adv[0]),
            .v        (v_q[0]),
            .d        (op_q)
         );

         // Stage 0 carries operands; its product view feeds stage 1.
         assign {mul_a, mul_b} = op_q;
         assign d_q[0]         = prod;

         for (genvar s = 1; s < LAT; s++) begin : g_stage
            tytra_pipe_stage #(.W(OUTW)) u_stage (
               .clk      (clk),
               .rst      (rst),
               .adv_next (adv[s+1]),
               .v_in     (v_q[s-1]),
               .d_in     (d_q[s-1]),
               .adv      (adv[s]),
               .v        (v_q[s]),
               .d        (d_q[s])
            );
         end
      end
   endgenerate

   assign ovalid = v_q[LAT-1];
   assign out1   = d_q[LAT-1];
   assign busy   = |v_q;

endmodule

// File: tb/tb_tytra_map_mul_pipe.sv
// Self-checking bench: four node configurations share one stimulus stream;
// a per-node scoreboard checks every delivered item, directed asserts check timing and stalls.
module tb_tytra_map_mul_pipe;

   logic        clk;
   logic        rst;
   logic        ivalid_in1;
   logic        ivalid_in2;
   logic [31:0] in1;
   logic [31:0] in2;
   logic        oready;

   logic        iready_v [4];
   logic        ovalid_v [4];
   logic        busy_v   [4];
   logic [31:0] out1_a;
   logic [31:0] out1_b;
   logic [63:0] out1_c;
   logic [31:0] out1_d;
   logic [63:0] out1_w   [4];

   int n_cmp  = 0;
   int n_fail = 0;

   logic [63:0] sb [4][$];

   // 0: defaults (LAT 2, constant 432, unsigned, 32-bit out)
   tytra_map_mul_pipe u_dut_a (
      .clk(clk), .rst(rst), .ivalid_in1(ivalid_in1), .in1(in1), .ivalid_in2(ivalid_in2), .in2(in2),
      .iready(iready_v[0]), .ovalid(ovalid_v[0]), .out1(out1_a), .oready(oready), .busy(busy_v[0])
   );

   // 1: constant mode, four stages
   tytra_map_mul_pipe #(.LAT(4)) u_dut_b (
      .clk(clk), .rst(rst), .ivalid_in1(ivalid_in1), .in1(in1), .ivalid_in2(ivalid_in2), .in2(in2),
      .iready(iready_v[1]), .ovalid(ovalid_v[1]), .out1(out1_b), .oready(oready), .busy(busy_v[1])
   );

   // 2: two streams, signed, full 64-bit product
   tytra_map_mul_pipe #(.USE_CONST(1'b0), .SIGNED(1'b1), .OUTW(64)) u_dut_c (
      .clk(clk), .rst(rst), .ivalid_in1(ivalid_in1), .in1(in1), .ivalid_in2(ivalid_in2), .in2(in2),
      .iready(iready_v[2]), .ovalid(ovalid_v[2]), .out1(out1_c), .oready(oready), .busy(busy_v[2])
   );

   // 3: two streams, unsigned, truncated to 32 bits
   tytra_map_mul_pipe #(.USE_CONST(1'b0)) u_dut_d (
      .clk(clk), .rst(rst), .ivalid_in1(ivalid_in1), .in1(in1), .ivalid_in2(ivalid_in2), .in2(in2),
      .iready(iready_v[3]), .ovalid(ovalid_v[3]), .out1(out1_d), .oready(oready), .busy(busy_v[3])
   );

   always_comb begin
      out1_w[0] = {32'b0, out1_a};
      out1_w[1] = {32'b0, out1_b};
      out1_w[2] = out1_c;
      out1_w[3] = {32'b0, out1_d};
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input int k, input logic [31:0] a, input logic [31:0] b);
      longint p;
      case (k)
         0, 1: return {32'b0, a * 32'd432};
         2: begin
            p = longint'(signed'(a)) * longint'(signed'(b));
            return p;
         end
         default: return {32'b0, a * b};
      endcase
   endfunction

   function automatic logic node_ivalid(input int k);
      return (k < 2) ? ivalid_in1 : (ivalid_in1 & ivalid_in2);
   endfunction

   // Scoreboard: pop on delivery first, then push the item accepted at the coming edge.
   always @(negedge clk) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) sb[k].delete();
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (ovalid_v[k] && oready) begin
               check($sformatf("sb_nonempty%0d", k), 64'(sb[k].size() != 0), 64'd1);
               if (sb[k].size() != 0) check($sformatf("sb_out%0d", k), out1_w[k], sb[k].pop_front());
            end
            if (node_ivalid(k) && iready_v[k]) sb[k].push_back(model(k, in1, in2));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic any_busy();
      return busy_v[0] | busy_v[1] | busy_v[2] | busy_v[3];
   endfunction

   function automatic int sb_total();
      return sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size();
   endfunction

   task automatic drain();
      int n;
      n = 0;
      ivalid_in1 = 1'b0;
      ivalid_in2 = 1'b0;
      oready     = 1'b1;
      while (n < 50 && (any_busy() || sb_total() != 0)) begin
         tick();
         n++;
      end
      check("drain_idle", {63'b0, any_busy()}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int i;
      logic acc;

      rst = 1'b1; ivalid_in1 = 1'b0; ivalid_in2 = 1'b0; in1 = '0; in2 = '0; oready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rst_ovalid%0d", k), {63'b0, ovalid_v[k]}, 64'd0);
         check($sformatf("rst_out1_%0d", k), out1_w[k], 64'd0);
         check($sformatf("rst_busy%0d", k), {63'b0, busy_v[k]}, 64'd0);
         check($sformatf("rst_iready%0d", k), {63'b0, iready_v[k]}, 64'd1);
      end

      // Constant mode latency: 5 * 432
      in1 = 32'd5; ivalid_in1 = 1'b1;
      tick();
      ivalid_in1 = 1'b0;
      check("lat_ovalid_early", {63'b0, ovalid_v[0]}, 64'd0);
      check("lat_busy1", {63'b0, busy_v[0]}, 64'd1);
      tick();
      check("lat_ovalid", {63'b0, ovalid_v[0]}, 64'd1);
      check("lat_out1", out1_w[0], 64'd2160);
      check("lat_busy2", {63'b0, busy_v[0]}, 64'd1);
      tick();
      check("lat_ovalid_after", {63'b0, ovalid_v[0]}, 64'd0);
      check("lat_busy_after", {63'b0, busy_v[0]}, 64'd0);
      drain();

      // Backpressure: stall cycles 3..6 with both stages of the default node full
      i = 1;
      for (int c = 0; c < 30 && i <= 5; c++) begin
         oready     = !(c >= 3 && c < 7);
         ivalid_in1 = 1'b1;
         in1        = 32'(i);
         #1;
         if (c >= 3 && c < 7) begin
            check("bp_iready_low", {63'b0, iready_v[0]}, 64'd0);
            check("bp_ovalid_hold", {63'b0, ovalid_v[0]}, 64'd1);
            check("bp_out1_hold", out1_w[0], 64'd864);
         end
         acc = iready_v[0];
         tick();
         if (acc) i++;
      end
      check("bp_all_accepted", 64'(i), 64'd6);
      drain();

      // Bubble collapse on the four-stage node
      oready = 1'b0; in1 = 32'd3; ivalid_in1 = 1'b1;
      tick();
      ivalid_in1 = 1'b0;
      tick(); tick();
      in1 = 32'd4; ivalid_in1 = 1'b1;
      tick();
      ivalid_in1 = 1'b0;
      tick(); tick(); tick();
      check("bc_ovalid", {63'b0, ovalid_v[1]}, 64'd1);
      check("bc_out1", out1_w[1], 64'd1296);
      check("bc_iready_empty_s0", {63'b0, iready_v[1]}, 64'd1);
      in1 = 32'd6; ivalid_in1 = 1'b1;
      #1;
      check("bc_iready_third", {63'b0, iready_v[1]}, 64'd1);
      tick();
      in1 = 32'd7;
      #1;
      check("bc_iready_fourth", {63'b0, iready_v[1]}, 64'd1);
      tick();
      in1 = 32'd8;
      #1;
      check("bc_iready_full", {63'b0, iready_v[1]}, 64'd0);
      check("bc_out1_stable", out1_w[1], 64'd1296);
      tick();
      drain();

      // Two-stream join: in2 not valid means no transfer
      in1 = 32'd5; in2 = 32'd5; ivalid_in1 = 1'b1; ivalid_in2 = 1'b0;
      tick(); tick();
      check("join_busy_c", {63'b0, busy_v[2]}, 64'd0);
      check("join_busy_d", {63'b0, busy_v[3]}, 64'd0);
      in1 = 32'd7; in2 = 32'd9; ivalid_in2 = 1'b1;
      tick();
      ivalid_in1 = 1'b0; ivalid_in2 = 1'b0;
      tick();
      check("join_ovalid_c", {63'b0, ovalid_v[2]}, 64'd1);
      check("join_out1_c", out1_w[2], 64'd63);
      check("join_out1_d", out1_w[3], 64'd63);
      drain();

      // Signed product and unsigned truncation
      in1 = 32'hFFFF_FFFD; in2 = 32'd7; ivalid_in1 = 1'b1; ivalid_in2 = 1'b1;
      tick();
      in1 = 32'h0001_0000; in2 = 32'h0001_0000;
      tick();
      ivalid_in1 = 1'b0; ivalid_in2 = 1'b0;
      check("signed_out1_c", out1_w[2], 64'hFFFF_FFFF_FFFF_FFEB);
      check("signed_low_d", out1_w[3], 64'h0000_0000_FFFF_FFEB);
      tick();
      check("wrap_out1_d", out1_w[3], 64'd0);
      check("wide_out1_c", out1_w[2], 64'h0000_0001_0000_0000);
      drain();

      // Reset with two items in flight
      in1 = 32'd10; in2 = 32'd2; ivalid_in1 = 1'b1; ivalid_in2 = 1'b1;
      tick();
      in1 = 32'd11;
      tick();
      rst = 1'b1; ivalid_in1 = 1'b0; ivalid_in2 = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("mid_rst_ovalid%0d", k), {63'b0, ovalid_v[k]}, 64'd0);
         check($sformatf("mid_rst_out1_%0d", k), out1_w[k], 64'd0);
         check($sformatf("mid_rst_busy%0d", k), {63'b0, busy_v[k]}, 64'd0);
         check($sformatf("mid_rst_iready%0d", k), {63'b0, iready_v[k]}, 64'd1);
      end
      in1 = 32'd1; in2 = 32'd1; ivalid_in1 = 1'b1; ivalid_in2 = 1'b1;
      tick();
      ivalid_in1 = 1'b0; ivalid_in2 = 1'b0;
      tick();
      check("post_rst_ovalid", {63'b0, ovalid_v[0]}, 64'd1);
      check("post_rst_out1", out1_w[0], 64'd432);
      drain();

      for (int k = 0; k < 4; k++)
         check($sformatf("sb_empty%0d", k), 64'(sb[k].size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
